serv_mac_buf: RTL
=================

Name: serv_mac_buf

Overview:
- Bit-serial result buffer that sits on the far side of the ALU result path.
- Capture direction: deserializes the W-bit-per-cycle rd stream into a 32-bit word and offers it on a parallel valid/ready port.
- Replay direction: serializes the held word back, LSB-first, to drive the ALU buffer operand during MAC step 2.
- One register file serves both directions, so a step-1 product is replayed without re-reading the register file.

Parameters:
- W, 1, serial datapath width in bits per cycle; legal values 1, 2, 4, 8.
- B, W-1, MSB index of the serial buses.
- XLEN, 32, word width; XLEN % W must be 0.

Ports:
- clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  serial beat strobe; same meaning as ALU enable, one beat per cycle while high.
- i_cap_start  in  1  pulse: begin capturing a word from i_rd.
- i_rd  in  W  serial result beat, LSB-first.
- o_word  out  XLEN  held parallel word.
- o_word_valid  out  1  held word available to the parallel consumer.
- i_word_ready  in  1  parallel consumer accepts o_word.
- i_play_start  in  1  pulse: begin replaying the held word.
- o_buf  out  W  serial replay beat, to ALU i_buf.
- o_busy  out  1  high in CAPTURE or PLAY.

Behaviour:
- Reset (async assert, sync release): state=IDLE, word=0, cnt=0, o_word_valid=0, o_busy=0, o_buf=0.
- State register uses encodings IDLE, CAPTURE, HOLD, PLAY.
- cnt is a beat counter of width clog2(XLEN/W); last beat is cnt==XLEN/W-1.
- IDLE:
  - i_cap_start -> CAPTURE, cnt=0.
  - i_play_start (if no i_cap_start) -> PLAY, cnt=0.
  - i_cap_start has priority over i_play_start.
- CAPTURE:
  - Each cycle with i_en=1: word[cnt*W +: W] <= i_rd, cnt++.
  - Cycles with i_en=0 hold all state.
  - On the last beat: -> HOLD, cnt wraps to 0, o_word_valid=1 from the next cycle.
  - i_cap_start and i_play_start are ignored.
- Capture latency: o_word_valid rises in the cycle after the (XLEN/W)-th enabled beat. With continuous i_en that is XLEN/W+1 cycles after the i_cap_start cycle.
- HOLD:
  - o_word_valid=1; o_word is stable.
  - i_word_ready=1 -> valid clears next cycle, -> IDLE; the word is retained for later replay.
  - i_play_start -> PLAY, valid clears.
  - i_play_start together with i_word_ready: the handshake completes and PLAY is entered.
  - i_cap_start in HOLD -> CAPTURE; valid clears and the old word is overwritten (consumer drop is intentional).
  - Priority: cap_start > play_start > ready.
- PLAY:
  - o_buf = word[cnt*W +: W] combinationally.
  - cnt++ on each i_en=1 cycle; on the last enabled beat -> IDLE.
  - The word is unchanged, so repeated replays return identical data.
  - Starts are ignored during PLAY.
- o_buf = 0 outside PLAY, so the ALU can safely OR it.
- o_word always reflects the register contents, including partial contents during CAPTURE. It is only meaningful while o_word_valid=1.
- Reset mid-CAPTURE or mid-PLAY: immediate return to the reset values; the partial word is discarded.
- No arithmetic beyond the counter; the counter wraps modulo XLEN/W.

Decomposition:
- Shared package serv_mac_pkg holds:
  - State enum (IDLE, CAPTURE, HOLD, PLAY).
  - XLEN constant.
  - Beat-count function clog2(XLEN/W).
- One natural sub-module, serv_beat_cnt: an enable-gated, wrapping beat counter with a last-beat flag. It is reusable wherever serial beats are counted.

Test Plan:
- W=1, reset, i_cap_start, 32 beats of 0xA5A5_0F0F LSB-first with i_en=1 -> o_word_valid=1 at cycle 33, o_word=0xA5A50F0F, o_busy=0.
- W=4, capture 0x1234_5678 with i_en toggling every other cycle -> valid only after 8 enabled beats; gaps freeze cnt.
- W=1, HOLD with word 0x8000_0001, assert i_play_start and i_word_ready together -> valid drops next cycle; o_buf emits 1, then 30 zeros, then 1; then IDLE, o_buf=0.
- Replay the same word twice from IDLE -> identical serial streams.
- i_rst_n low at capture beat 10 -> o_word=0, o_word_valid=0, o_busy=0 immediately; recapture of 0xFFFF_FFFF succeeds.
- In HOLD (word 0xDEAD_BEEF), i_cap_start with i_word_ready -> CAPTURE entered, valid=0, new word 0x0000_0003 replaces the old one.

Source files
------------

// File: rtl/serv_mac_pkg.sv
// rtl/serv_mac_pkg.sv - shared state encoding, word width and beat-counter sizing
package serv_mac_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLD    = 2'd2,
      ST_PLAY    = 2'd3
   } state_t;

   // Counter width for xlen/w beats; never narrower than one bit.
   function automatic int beat_cnt_w(input int xlen, input int w);
      int n;
      n = xlen / w;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serv_beat_cnt.sv
// rtl/serv_beat_cnt.sv - enable-gated wrapping beat counter with last-beat flag
module serv_beat_cnt #(
   parameter int N  = 32,
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_last
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] r_cnt;

   // Advance one beat per enabled cycle, wrapping after the last beat.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/serv_mac_buf.sv
// rtl/serv_mac_buf.sv - bit-serial result buffer: captures rd into a word, replays it as buf
module serv_mac_buf
   import serv_mac_pkg::*;
#(
   parameter int W    = 1,
   parameter int B    = W - 1,
   parameter int XLEN = serv_mac_pkg::XLEN
) (
   input  logic            clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic            i_cap_start,
   input  logic [B:0]      i_rd,
   output logic [XLEN-1:0] o_word,
   output logic            o_word_valid,
   input  logic            i_word_ready,
   input  logic            i_play_start,
   output logic [B:0]      o_buf,
   output logic            o_busy
);

   localparam int NB = XLEN / W;
   localparam int CW = beat_cnt_w(XLEN, W);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_word;
   logic [CW-1:0]   w_cnt;
   logic            w_last;
   logic            w_run;
   logic            w_beat;

   // Counter only runs while shifting; it sits at zero otherwise so each
   // capture or replay begins at the LSB beat.
   assign w_run  = (r_state == ST_CAPTURE) || (r_state == ST_PLAY);
   assign w_beat = w_run && i_en;

   serv_beat_cnt #(
      .N  (NB),
      .CW (CW)
   ) u_beat_cnt (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_clr   (!w_run),
      .i_en    (w_beat),
      .o_cnt   (w_cnt),
      .o_last  (w_last)
   );

   // State register.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and status outputs; a fresh capture outranks replay, which
   // outranks a plain consumer handshake.
   always_comb begin
      w_state_nxt  = r_state;
      o_word_valid = (r_state == ST_HOLD);
      o_busy       = w_run;
      case (r_state)
         ST_IDLE: begin
            if (i_cap_start)       w_state_nxt = ST_CAPTURE;
            else if (i_play_start) w_state_nxt = ST_PLAY;
         end
         ST_CAPTURE: begin
            if (i_en && w_last)    w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (i_cap_start)       w_state_nxt = ST_CAPTURE;
            else if (i_play_start) w_state_nxt = ST_PLAY;
            else if (i_word_ready) w_state_nxt = ST_IDLE;
         end
         ST_PLAY: begin
            if (i_en && w_last)    w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Deposit each enabled capture beat into its slot of the word.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_word <= '0;
      end else if ((r_state == ST_CAPTURE) && i_en) begin
         for (int b = 0; b < NB; b++) begin
            if (w_cnt == CW'(b)) r_word[b*W +: W] <= i_rd;
         end
      end
   end

   // Replay beat selected by the counter; zero outside PLAY so it can be ORed.
   always_comb begin
      o_buf = '0;
      if (r_state == ST_PLAY) begin
         for (int b = 0; b < NB; b++) begin
            if (w_cnt == CW'(b)) o_buf = r_word[b*W +: W];
         end
      end
   end

   assign o_word = r_word;

endmodule
